// File: rtl/btb_update_ctrl_pkg.sv
// Shared definitions for the BTB update controller: geometry, FSM state
// encoding and the pending-update entry layout.
package btb_update_ctrl_pkg;

  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned BUFFER_SIZE = 8;
  localparam int unsigned TAG_SIZE    = 8;
  localparam int unsigned TABLE_NUMS  = 256;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned FIFO_PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OVF_W       = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [BUFFER_SIZE-1:0] idx;
    logic [TAG_SIZE-1:0]    tag;
    logic [WORD_SIZE-1:0]   target;
    logic                   taken;
  } upd_entry_t;

  // Split a resolved branch into the BTB index/tag/target/outcome fields.
  function automatic upd_entry_t make_entry(input logic [WORD_SIZE-1:0] pc,
                                            input logic [WORD_SIZE-1:0] target,
                                            input logic                 taken);
    upd_entry_t e;
    e.idx    = pc[BUFFER_SIZE-1:0];
    e.tag    = pc[WORD_SIZE-1 -: TAG_SIZE];
    e.target = target;
    e.taken  = taken;
    return e;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Signal bundle between the EX branch unit / BTB write port / fetch and the
// BTB update controller.
//   master : the controller (consumes resolutions, drives BTB writes, redirect)
//   slave  : the surrounding pipeline and BTB
interface btb_update_ctrl_if;

  logic                                         flush_req;
  logic                                         res_valid;
  logic [btb_update_ctrl_pkg::WORD_SIZE-1:0]    res_pc;
  logic [btb_update_ctrl_pkg::WORD_SIZE-1:0]    res_target;
  logic                                         res_taken;
  logic                                         res_pred_valid;
  logic [btb_update_ctrl_pkg::WORD_SIZE-1:0]    res_pred_pc;
  logic                                         btb_wr_ready;

  logic                                         btb_wr_en;
  logic                                         btb_wr_clear;
  logic [btb_update_ctrl_pkg::BUFFER_SIZE-1:0]  btb_wr_idx;
  logic [btb_update_ctrl_pkg::TAG_SIZE-1:0]     btb_wr_tag;
  logic [btb_update_ctrl_pkg::WORD_SIZE-1:0]    btb_wr_target;
  logic                                         btb_wr_taken;
  logic                                         btb_lookup_en;
  logic                                         redirect_valid;
  logic [btb_update_ctrl_pkg::WORD_SIZE-1:0]    redirect_pc;
  logic [btb_update_ctrl_pkg::OVF_W-1:0]        overflow_cnt;
  logic                                         busy;

  modport master (
    input  flush_req, res_valid, res_pc, res_target, res_taken,
           res_pred_valid, res_pred_pc, btb_wr_ready,
    output btb_wr_en, btb_wr_clear, btb_wr_idx, btb_wr_tag, btb_wr_target,
           btb_wr_taken, btb_lookup_en, redirect_valid, redirect_pc,
           overflow_cnt, busy
  );

  modport slave (
    output flush_req, res_valid, res_pc, res_target, res_taken,
           res_pred_valid, res_pred_pc, btb_wr_ready,
    input  btb_wr_en, btb_wr_clear, btb_wr_idx, btb_wr_tag, btb_wr_target,
           btb_wr_taken, btb_lookup_en, redirect_valid, redirect_pc,
           overflow_cnt, busy
  );

endinterface

// File: rtl/btb_upd_fifo.sv
// Pending BTB update queue. Synchronous FIFO; a pop in the same cycle frees
// the slot so a push into a full queue is accepted.
//   clk_i/rst_i : clock, synchronous active-high reset
//   clear_i     : drop all contents
//   push_i/din_i, pop_i/dout_o : enqueue / head of queue
//   full_o/empty_o : occupancy flags
module btb_upd_fifo
  import btb_update_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       push_i,
  input  upd_entry_t din_i,
  input  logic       pop_i,
  output upd_entry_t dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned IDX_W = FIFO_PTR_W - 1;

  upd_entry_t            mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic                  do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty; pointers wrap naturally.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
    end
  end

  // Storage.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[IDX_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: runs the table clear walk after reset/flush, drains
// queued resolved-branch updates into the BTB write port, counts dropped
// updates and issues a registered fetch redirect on mispredict.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : resolution inputs, BTB write port, lookup gate, redirect,
//                overflow counter and busy (master side)
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
(
  input logic               Clk,
  input logic               Reset,
  btb_update_ctrl_if.master bus
);

  state_e                 state_q, state_d;
  logic [BUFFER_SIZE-1:0] clr_idx_q, clr_idx_d;
  logic                   redirect_valid_q;
  logic [WORD_SIZE-1:0]   redirect_pc_q;
  logic [OVF_W-1:0]       overflow_cnt_q;

  logic       mispredict_c, enq_req_c, push_c, pop_c;
  logic       fifo_full, fifo_empty;
  upd_entry_t fifo_head, new_entry;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next state: flush restarts the walk from any state.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (bus.flush_req) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (bus.btb_wr_ready) begin
            clr_idx_d = clr_idx_q + BUFFER_SIZE'(1);
            if (clr_idx_q == BUFFER_SIZE'(TABLE_NUMS - 1)) state_d = RUN;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = CLEAR;
      endcase
    end
  end

  // Outputs: clear writes during the walk, queue-head writes in RUN.
  always_comb begin
    bus.btb_wr_en     = 1'b0;
    bus.btb_wr_clear  = 1'b0;
    bus.btb_wr_idx    = '0;
    bus.btb_wr_tag    = '0;
    bus.btb_wr_target = '0;
    bus.btb_wr_taken  = 1'b0;
    bus.btb_lookup_en = 1'b0;
    pop_c             = 1'b0;
    case (state_q)
      CLEAR: begin
        bus.btb_wr_en    = 1'b1;
        bus.btb_wr_clear = 1'b1;
        bus.btb_wr_idx   = clr_idx_q;
      end
      RUN: begin
        bus.btb_lookup_en = 1'b1;
        if (!fifo_empty) begin
          bus.btb_wr_en     = 1'b1;
          bus.btb_wr_idx    = fifo_head.idx;
          bus.btb_wr_tag    = fifo_head.tag;
          bus.btb_wr_target = fifo_head.target;
          bus.btb_wr_taken  = fifo_head.taken;
          pop_c             = bus.btb_wr_ready;
        end
      end
      default: ;
    endcase
    bus.busy = (state_q != RUN) || !fifo_empty;
  end

  assign mispredict_c = bus.res_valid &&
                        ((bus.res_taken != bus.res_pred_valid) ||
                         (bus.res_taken && (bus.res_pred_pc != bus.res_target)));

  // Only branches the BTB could hold or mispredicted-as-taken get recorded;
  // a flush in the same cycle discards the update.
  assign enq_req_c = bus.res_valid && (bus.res_taken || bus.res_pred_valid) &&
                     !bus.flush_req;
  assign push_c    = enq_req_c && (!fifo_full || pop_c);
  assign new_entry = make_entry(bus.res_pc, bus.res_target, bus.res_taken);

  btb_upd_fifo u_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clear_i (bus.flush_req),
    .push_i  (push_c),
    .din_i   (new_entry),
    .pop_i   (pop_c),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Redirect and dropped-update counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      overflow_cnt_q   <= '0;
    end else begin
      redirect_valid_q <= mispredict_c;
      if (mispredict_c) begin
        redirect_pc_q <= bus.res_taken ? bus.res_target
                                       : bus.res_pc + WORD_SIZE'(1);
      end
      if (enq_req_c && !push_c && (overflow_cnt_q != '1)) begin
        overflow_cnt_q <= overflow_cnt_q + OVF_W'(1);
      end
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.overflow_cnt   = overflow_cnt_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_btb_update_ctrl;
  import btb_update_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btb_update_ctrl_if bus();

  btb_update_ctrl dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Model state
  upd_entry_t  mq[$];
  bit          m_valid;
  bit          m_clearing;
  int          m_walk;
  int          m_ovf;
  bit          m_rv;
  logic [15:0] m_rpc;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow directly from the model's walk position and queue.
  task automatic model_compare();
    upd_entry_t h;
    if (!m_valid) return;
    chk("wr_en", 32'(bus.btb_wr_en), 32'(m_clearing || mq.size() > 0));
    chk("lookup_en", 32'(bus.btb_lookup_en), 32'(!m_clearing));
    chk("busy", 32'(bus.busy), 32'(m_clearing || mq.size() > 0));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    if (m_rv) chk("redirect_pc", 32'(bus.redirect_pc), 32'(m_rpc));
    chk("overflow_cnt", 32'(bus.overflow_cnt), 32'(m_ovf));
    if (m_clearing) begin
      chk("wr_clear", 32'(bus.btb_wr_clear), 32'd1);
      chk("wr_idx", 32'(bus.btb_wr_idx), 32'(m_walk));
      chk("wr_tag", 32'(bus.btb_wr_tag), 32'd0);
      chk("wr_target", 32'(bus.btb_wr_target), 32'd0);
      chk("wr_taken", 32'(bus.btb_wr_taken), 32'd0);
    end else if (mq.size() > 0) begin
      h = mq[0];
      chk("wr_clear", 32'(bus.btb_wr_clear), 32'd0);
      chk("wr_idx", 32'(bus.btb_wr_idx), 32'(h.idx));
      chk("wr_tag", 32'(bus.btb_wr_tag), 32'(h.tag));
      chk("wr_target", 32'(bus.btb_wr_target), 32'(h.target));
      chk("wr_taken", 32'(bus.btb_wr_taken), 32'(h.taken));
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    bit mis, want, popped;
    upd_entry_t e;
    m_valid = 1'b1;
    if (rst) begin
      mq.delete();
      m_clearing = 1'b1;
      m_walk = 0;
      m_ovf = 0;
      m_rv = 1'b0;
      m_rpc = 16'h0;
      return;
    end
    mis = bus.res_valid && ((bus.res_taken != bus.res_pred_valid) ||
                            (bus.res_taken && bus.res_pred_pc != bus.res_target));
    m_rv = mis;
    if (mis) m_rpc = bus.res_taken ? bus.res_target : 16'((32'(bus.res_pc) + 1) % 65536);
    popped = !m_clearing && mq.size() > 0 && bus.btb_wr_ready;
    if (bus.flush_req) begin
      mq.delete();
      m_clearing = 1'b1;
      m_walk = 0;
      return;
    end
    if (popped) void'(mq.pop_front());
    want = bus.res_valid && (bus.res_taken || bus.res_pred_valid);
    if (want) begin
      if (mq.size() < 4) begin
        e.idx    = 8'(bus.res_pc % 256);
        e.tag    = 8'(bus.res_pc / 256);
        e.target = bus.res_target;
        e.taken  = bus.res_taken;
        mq.push_back(e);
      end else if (m_ovf < 255) begin
        m_ovf++;
      end
    end
    if (m_clearing && bus.btb_wr_ready) begin
      if (m_walk == 255) m_clearing = 1'b0;
      m_walk = (m_walk + 1) % 256;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_compare();
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    sample();
    step();
  endtask

  task automatic idle_res();
    bus.flush_req      = 1'b0;
    bus.res_valid      = 1'b0;
    bus.res_pc         = 16'h0;
    bus.res_target     = 16'h0;
    bus.res_taken      = 1'b0;
    bus.res_pred_valid = 1'b0;
    bus.res_pred_pc    = 16'h0;
  endtask

  task automatic set_res(input logic [15:0] pc, input logic [15:0] tgt, input logic taken,
                         input logic pv, input logic [15:0] ppc);
    bus.res_valid      = 1'b1;
    bus.res_pc         = pc;
    bus.res_target     = tgt;
    bus.res_taken      = taken;
    bus.res_pred_valid = pv;
    bus.res_pred_pc    = ppc;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_valid = 1'b0;
    rst = 1'b1;
    idle_res();
    bus.btb_wr_ready = 1'b1;

    // Reset state
    step();
    sample();
    chk("rst_lookup_en", 32'(bus.btb_lookup_en), 32'd0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_redirect_pc", 32'(bus.redirect_pc), 32'd0);
    chk("rst_overflow", 32'(bus.overflow_cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    step();
    rst = 1'b0;

    // Clear walk: 256 writes at idx 0..255
    for (int i = 0; i < 256; i++) begin
      sample();
      chk("walk_clear", 32'(bus.btb_wr_clear), 32'd1);
      chk("walk_idx", 32'(bus.btb_wr_idx), 32'(i));
      step();
    end

    // Taken branch not predicted
    bus.btb_wr_ready = 1'b0;
    set_res(16'h1234, 16'h2000, 1'b1, 1'b0, 16'h0);
    sample();
    chk("run_lookup_en", 32'(bus.btb_lookup_en), 32'd1);
    chk("run_busy", 32'(bus.busy), 32'd0);
    chk("run_wr_en", 32'(bus.btb_wr_en), 32'd0);
    step();
    idle_res();
    sample();
    chk("mp1_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    chk("mp1_redirect_pc", 32'(bus.redirect_pc), 32'h2000);
    chk("mp1_wr_idx", 32'(bus.btb_wr_idx), 32'h34);
    chk("mp1_wr_tag", 32'(bus.btb_wr_tag), 32'h12);
    chk("mp1_wr_target", 32'(bus.btb_wr_target), 32'h2000);
    chk("mp1_wr_taken", 32'(bus.btb_wr_taken), 32'd1);
    step();
    sample();
    chk("mp1_redirect_one_cycle", 32'(bus.redirect_valid), 32'd0);
    step();
    bus.btb_wr_ready = 1'b1;
    cycle();

    // Predicted taken, actually not taken, PC wraps
    bus.btb_wr_ready = 1'b0;
    set_res(16'hFFFF, 16'h1111, 1'b0, 1'b1, 16'h2000);
    cycle();
    idle_res();
    sample();
    chk("mp2_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    chk("mp2_redirect_pc_wrap", 32'(bus.redirect_pc), 32'h0000);
    chk("mp2_wr_taken", 32'(bus.btb_wr_taken), 32'd0);
    chk("mp2_wr_idx", 32'(bus.btb_wr_idx), 32'hFF);
    step();
    bus.btb_wr_ready = 1'b1;
    cycle();

    // Six correctly predicted taken branches with ready low
    bus.btb_wr_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_res(16'h0A10 + 16'(k), 16'h3000 + 16'(k), 1'b1, 1'b1, 16'h3000 + 16'(k));
      cycle();
    end
    idle_res();
    sample();
    chk("ovf_count", 32'(bus.overflow_cnt), 32'd2);
    chk("ovf_no_redirect", 32'(bus.redirect_valid), 32'd0);
    step();
    bus.btb_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("drain_idx", 32'(bus.btb_wr_idx), 32'h10 + 32'(k));
      chk("drain_target", 32'(bus.btb_wr_target), 32'h3000 + 32'(k));
      step();
    end
    sample();
    chk("drain_empty", 32'(bus.btb_wr_en), 32'd0);
    step();

    // Full queue with simultaneous push and pop
    bus.btb_wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_res(16'h0B20 + 16'(k), 16'h4000, 1'b1, 1'b1, 16'h4000);
      cycle();
    end
    bus.btb_wr_ready = 1'b1;
    set_res(16'h0B30, 16'h4000, 1'b1, 1'b1, 16'h4000);
    cycle();
    idle_res();
    sample();
    chk("full_pushpop_ovf", 32'(bus.overflow_cnt), 32'd2);
    chk("full_pushpop_head", 32'(bus.btb_wr_idx), 32'h21);
    step();
    for (int k = 0; k < 5; k++) cycle();

    // Flush with queued entries and a same-cycle mispredict
    bus.btb_wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_res(16'h0C40 + 16'(k), 16'h6000, 1'b1, 1'b1, 16'h6000);
      cycle();
    end
    bus.flush_req = 1'b1;
    set_res(16'h4242, 16'h5555, 1'b1, 1'b0, 16'h0);
    cycle();
    idle_res();
    sample();
    chk("flush_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    chk("flush_redirect_pc", 32'(bus.redirect_pc), 32'h5555);
    chk("flush_lookup_en", 32'(bus.btb_lookup_en), 32'd0);
    chk("flush_wr_clear", 32'(bus.btb_wr_clear), 32'd1);
    chk("flush_wr_idx", 32'(bus.btb_wr_idx), 32'd0);
    chk("flush_overflow", 32'(bus.overflow_cnt), 32'd2);
    step();
    bus.btb_wr_ready = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    sample();
    chk("walk_mid_idx", 32'(bus.btb_wr_idx), 32'd10);
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    sample();
    chk("walk_restart_idx", 32'(bus.btb_wr_idx), 32'd0);
    step();
    for (int t = 0; t < 400 && !bus.btb_lookup_en; t++) cycle();
    sample();
    chk("walk_done", 32'(bus.btb_lookup_en), 32'd1);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] tgt;
      rst = ($urandom_range(0, 2999) == 0);
      bus.flush_req = ($urandom_range(0, 1499) == 0);
      tgt = 16'($urandom);
      bus.res_valid = ($urandom_range(0, 1) == 1);
      bus.res_pc = 16'($urandom);
      bus.res_target = tgt;
      bus.res_taken = ($urandom_range(0, 1) == 1);
      bus.res_pred_valid = ($urandom_range(0, 1) == 1);
      bus.res_pred_pc = ($urandom_range(0, 3) != 0) ? tgt : 16'($urandom);
      // Alternate long ready-low stretches to exercise overflow
      if ((c / 64) % 4 == 3) bus.btb_wr_ready = ($urandom_range(0, 9) == 0);
      else                   bus.btb_wr_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    rst = 1'b0;
    idle_res();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
